mc_load_port: RTL and testbench

Load access port that sits directly upstream of the memory controller, connecting one dataflow load operation to one load channel of `mem_controller` (`ldAddr*` / `ldData*`). It forwards load addresses to the controller under a credit limit and buffers returning load data in an in-order response FIFO. The consumer can therefore stall without stalling the controller's read arbiter. Because the FIFO can never overflow, the controller-facing data channel is always ready.

---
 rtl/mc_load_port_if.sv | 44 ++++
 rtl/mc_load_port.sv | 123 ++++++++++++
 tb/tb_mc_load_port.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_load_port_if.sv
// Handshake bundle for mc_load_port.
// It carries the dataflow-side load address and data channels and the
// memory-controller-side ldAddr/ldData channels.
interface mc_load_port_if #(
  parameter int DATA_TYPE = 32,
  parameter int ADDR_TYPE = 32
);
  logic [ADDR_TYPE-1:0] addrIn;
  logic                 addrIn_valid;
  logic                 addrIn_ready;
  logic [DATA_TYPE-1:0] dataOut;
  logic                 dataOut_valid;
  logic                 dataOut_ready;
  logic [ADDR_TYPE-1:0] ldAddrToMC;
  logic                 ldAddrToMC_valid;
  logic                 ldAddrToMC_ready;
  logic [DATA_TYPE-1:0] ldDataFromMC;
  logic                 ldDataFromMC_valid;
  logic                 ldDataFromMC_ready;

  // View from inside the load port
  modport slave (
    input  addrIn, addrIn_valid,
    output addrIn_ready,
    output dataOut, dataOut_valid,
    input  dataOut_ready,
    output ldAddrToMC, ldAddrToMC_valid,
    input  ldAddrToMC_ready,
    input  ldDataFromMC, ldDataFromMC_valid,
    output ldDataFromMC_ready
  );

  // View from the surrounding circuit (load op plus controller)
  modport master (
    output addrIn, addrIn_valid,
    input  addrIn_ready,
    input  dataOut, dataOut_valid,
    output dataOut_ready,
    input  ldAddrToMC, ldAddrToMC_valid,
    output ldAddrToMC_ready,
    output ldDataFromMC, ldDataFromMC_valid,
    input  ldDataFromMC_ready
  );
endinterface

// File: rtl/mc_load_port.sv
// mc_load_port: credit-limited load issue port in front of the memory controller.
// Addresses pass through combinationally while credit remains. Returning data is
// buffered in an in-order FIFO that is sized so the controller is never back-pressured.

// Simulation checker: the controller must never present data the FIFO cannot take.
module mc_load_port_chk (
  input logic clk,
  input logic rst,
  input logic data_valid,
  input logic data_ready
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(data_valid && !data_ready));
endmodule

module mc_load_port #(
  parameter int DATA_TYPE       = 32,
  parameter int ADDR_TYPE       = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic            clk,
  input logic            rst,
  mc_load_port_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  // FIFO pointers wrap explicitly because the depth need not be a power of two
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == LAST_PTR) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  logic [CNT_W-1:0]     r_outstanding;
  logic [CNT_W-1:0]     r_count;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [DATA_TYPE-1:0] r_mem [MAX_OUTSTANDING];

  logic w_credit;
  logic w_addr_ready;
  logic w_data_ready;
  logic w_out_valid;
  logic w_issue;
  logic w_enq;
  logic w_deq;

  // Credit is held until the consumer takes the data, so every issued load owns a FIFO slot
  assign w_credit     = (r_outstanding < MAX_CNT);
  assign w_addr_ready = bus.ldAddrToMC_ready && w_credit;
  assign w_data_ready = (r_count < MAX_CNT);
  assign w_out_valid  = (r_count != {CNT_W{1'b0}});

  assign w_issue = bus.addrIn_valid && w_addr_ready;
  assign w_enq   = bus.ldDataFromMC_valid && w_data_ready;
  assign w_deq   = w_out_valid && bus.dataOut_ready;

  assign bus.ldAddrToMC         = bus.addrIn;
  assign bus.ldAddrToMC_valid   = bus.addrIn_valid && w_credit;
  assign bus.addrIn_ready       = w_addr_ready;
  assign bus.ldDataFromMC_ready = w_data_ready;
  assign bus.dataOut            = r_mem[r_rd_ptr];
  assign bus.dataOut_valid      = w_out_valid;

  // Count loads issued to the controller but not yet delivered to the consumer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= {CNT_W{1'b0}};
    end else begin
      case ({w_issue, w_deq})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Track FIFO occupancy; a simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {CNT_W{1'b0}};
    end else begin
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Advance the write and read pointers on push and pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
    end else begin
      if (w_enq) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_deq) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
    end
  end

  // Store returning data; entries need no reset because occupancy gates their visibility
  always_ff @(posedge clk) begin
    if (w_enq && !rst) begin
      r_mem[r_wr_ptr] <= bus.ldDataFromMC;
    end
  end

  mc_load_port_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .data_valid (bus.ldDataFromMC_valid),
    .data_ready (w_data_ready)
  );
endmodule

// File: tb/tb_mc_load_port.sv
// Bench for mc_load_port (MAX_OUTSTANDING=3).
// The bench applies a table of directed vectors, then model-checked streaming,
// random wrap-around and mid-operation reset sequences.
module tb_mc_load_port;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MAXO = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_load_port_if #(.DATA_TYPE(DW), .ADDR_TYPE(AW)) u_bus ();

  mc_load_port #(.DATA_TYPE(DW), .ADDR_TYPE(AW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Directed vector record: inputs, then expected outputs for that cycle
  typedef struct {
    bit          chk;
    logic        rst;
    logic        av;
    logic [31:0] a;
    logic        mr;
    logic        lv;
    logic [31:0] ld;
    logic        dr;
    logic        e_ar;
    logic        e_mv;
    logic        e_dv;
    logic [31:0] e_do;
    logic        e_lr;
  } vec_t;
  vec_t tbl [18];

  // Reference model: the number of loads that hold credit, the data waiting for
  // the consumer, and a controller that returns addr*4 after a latency.
  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;
  int          m_out = 0;
  logic [31:0] m_fifo [$];
  rsp_t        ctl_q [$];
  logic [31:0] delivered [$];
  int          cyc = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          last_due = 0;
  int          obs_n, obs_first, obs_last;
  logic [31:0] obs_data;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a * 32'd4;
  endfunction

  task automatic model_cycle(input logic r, input logic av, input logic [31:0] a,
                             input logic mr, input logic dr, output logic issued);
    logic        lv;
    logic [31:0] ld;
    logic        credit, e_ar, e_mv, e_dv, e_lr, enq, deq;
    rsp_t        rsp;
    int          due;
    lv = (ctl_q.size() > 0) && (ctl_q[0].due <= cyc);
    ld = lv ? ctl_q[0].data : $urandom;
    rst = r;
    u_bus.addrIn_valid       = av;
    u_bus.addrIn             = a;
    u_bus.ldAddrToMC_ready   = mr;
    u_bus.ldDataFromMC_valid = lv;
    u_bus.ldDataFromMC       = ld;
    u_bus.dataOut_ready      = dr;
    #1;
    credit = (m_out < MAXO);
    e_ar   = mr && credit;
    e_mv   = av && credit;
    e_dv   = (m_fifo.size() != 0);
    e_lr   = (m_fifo.size() < MAXO);
    chk("addrIn_ready", u_bus.addrIn_ready, e_ar);
    chk("ldAddrToMC_valid", u_bus.ldAddrToMC_valid, e_mv);
    chk("ldAddrToMC", u_bus.ldAddrToMC, a);
    chk("dataOut_valid", u_bus.dataOut_valid, e_dv);
    chk("ldDataFromMC_ready", u_bus.ldDataFromMC_ready, e_lr);
    if (e_dv) chk("dataOut", u_bus.dataOut, m_fifo[0]);
    if (!r && u_bus.dataOut_valid && dr) begin
      if (obs_n == 0) obs_first = cyc;
      obs_last = cyc;
      obs_data = u_bus.dataOut;
      obs_n++;
    end
    issued = 1'b0;
    if (r) begin
      m_fifo.delete();
      ctl_q.delete();
      m_out    = 0;
      last_due = 0;
    end else begin
      issued = av && e_ar;
      enq    = lv && e_lr;
      deq    = e_dv && dr;
      if (deq) delivered.push_back(m_fifo.pop_front());
      if (enq) begin
        rsp = ctl_q.pop_front();
        m_fifo.push_back(rsp.data);
      end
      if (issued) begin
        due = cyc + $urandom_range(lat_hi, lat_lo);
        if (due < last_due) due = last_due;
        last_due = due;
        rsp.data = mem_fn(a);
        rsp.due  = due;
        ctl_q.push_back(rsp);
      end
      m_out = m_out + (issued ? 1 : 0) - (deq ? 1 : 0);
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        iss;
    logic        av;
    logic [31:0] idx;
    int          t0;

    //            chk  rst  av  addr    mr  lv  ld      dr   ar  mv  dv  dout    lr
    tbl[0]  = '{1'b0,1'b1,1'b1,32'h0, 1'b0,1'b0,32'h0,   1'b1,1'b0,1'b0,1'b0,32'h0,   1'b1};
    tbl[1]  = '{1'b1,1'b1,1'b1,32'h5, 1'b1,1'b1,32'hDEAD,1'b0,1'b1,1'b1,1'b0,32'h0,   1'b1};
    tbl[2]  = '{1'b1,1'b0,1'b1,32'h10,1'b1,1'b0,32'h0,   1'b1,1'b1,1'b1,1'b0,32'h0,   1'b1};
    tbl[3]  = '{1'b1,1'b0,1'b0,32'h10,1'b1,1'b1,32'hCAFE,1'b1,1'b1,1'b0,1'b0,32'h0,   1'b1};
    tbl[4]  = '{1'b1,1'b0,1'b0,32'h10,1'b1,1'b0,32'h0,   1'b1,1'b1,1'b0,1'b1,32'hCAFE,1'b1};
    tbl[5]  = '{1'b1,1'b0,1'b1,32'h20,1'b1,1'b0,32'h0,   1'b0,1'b1,1'b1,1'b0,32'h0,   1'b1};
    tbl[6]  = '{1'b1,1'b0,1'b1,32'h24,1'b1,1'b1,32'h111, 1'b0,1'b1,1'b1,1'b0,32'h0,   1'b1};
    tbl[7]  = '{1'b1,1'b0,1'b1,32'h28,1'b1,1'b1,32'h222, 1'b0,1'b1,1'b1,1'b1,32'h111, 1'b1};
    tbl[8]  = '{1'b1,1'b0,1'b1,32'h2C,1'b1,1'b1,32'h333, 1'b0,1'b0,1'b0,1'b1,32'h111, 1'b1};
    tbl[9]  = '{1'b1,1'b0,1'b1,32'h2C,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,1'b1,32'h111, 1'b0};
    tbl[10] = '{1'b1,1'b0,1'b1,32'h2C,1'b1,1'b0,32'h0,   1'b1,1'b0,1'b0,1'b1,32'h111, 1'b0};
    tbl[11] = '{1'b1,1'b0,1'b1,32'h2C,1'b1,1'b0,32'h0,   1'b0,1'b1,1'b1,1'b1,32'h222, 1'b1};
    tbl[12] = '{1'b1,1'b0,1'b1,32'h30,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,1'b1,32'h222, 1'b1};
    tbl[13] = '{1'b1,1'b0,1'b0,32'h30,1'b0,1'b0,32'h0,   1'b1,1'b0,1'b0,1'b1,32'h222, 1'b1};
    tbl[14] = '{1'b1,1'b0,1'b1,32'h40,1'b0,1'b0,32'h0,   1'b1,1'b0,1'b1,1'b1,32'h333, 1'b1};
    tbl[15] = '{1'b1,1'b0,1'b0,32'h40,1'b1,1'b1,32'h444, 1'b1,1'b1,1'b0,1'b0,32'h0,   1'b1};
    tbl[16] = '{1'b1,1'b0,1'b0,32'h40,1'b1,1'b0,32'h0,   1'b1,1'b1,1'b0,1'b1,32'h444, 1'b1};
    tbl[17] = '{1'b1,1'b0,1'b1,32'h50,1'b0,1'b0,32'h0,   1'b1,1'b0,1'b1,1'b0,32'h0,   1'b1};

    // Directed vectors: reset, single load, credit limit, full FIFO, pointer wrap
    for (int i = 0; i < 18; i++) begin
      rst                      = tbl[i].rst;
      u_bus.addrIn_valid       = tbl[i].av;
      u_bus.addrIn             = tbl[i].a;
      u_bus.ldAddrToMC_ready   = tbl[i].mr;
      u_bus.ldDataFromMC_valid = tbl[i].lv;
      u_bus.ldDataFromMC       = tbl[i].ld;
      u_bus.dataOut_ready      = tbl[i].dr;
      #1;
      if (tbl[i].chk) begin
        chk($sformatf("vec%0d addrIn_ready", i), u_bus.addrIn_ready, tbl[i].e_ar);
        chk($sformatf("vec%0d ldAddrToMC_valid", i), u_bus.ldAddrToMC_valid, tbl[i].e_mv);
        chk($sformatf("vec%0d dataOut_valid", i), u_bus.dataOut_valid, tbl[i].e_dv);
        chk($sformatf("vec%0d ldDataFromMC_ready", i), u_bus.ldDataFromMC_ready, tbl[i].e_lr);
        if (tbl[i].e_dv) chk($sformatf("vec%0d dataOut", i), u_bus.dataOut, tbl[i].e_do);
      end
      @(negedge clk);
    end

    // Streaming: 20 back-to-back loads, 1-cycle controller, consumer always ready
    lat_lo = 1;
    lat_hi = 1;
    obs_n  = 0;
    idx    = 32'd0;
    delivered.delete();
    t0 = cyc;
    for (int k = 0; k < 60 && delivered.size() < 20; k++) begin
      av = (idx < 32'd20);
      model_cycle(1'b0, av, idx, 1'b1, 1'b1, iss);
      if (iss) idx++;
    end
    chk("stream_outputs", obs_n, 20);
    chk("stream_no_bubbles", obs_last - obs_first, 19);
    chk("stream_first_latency", obs_first - t0, 2);
    chk("stream_last_data", obs_data, 32'd19 * 32'd4);

    // Random wrap-around: 100 loads, variable latency, toggling consumer ready
    lat_lo = 1;
    lat_hi = 3;
    idx    = 32'd0;
    delivered.delete();
    for (int k = 0; k < 3000 && delivered.size() < 100; k++) begin
      av = (idx < 32'd100) && ($urandom_range(3, 0) != 0);
      model_cycle(1'b0, av, $urandom, ($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), iss);
      if (iss) idx++;
    end
    chk("wrap_delivered", delivered.size(), 100);

    // Drain anything still in flight before the reset sequence
    for (int k = 0; k < 20; k++) model_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, iss);

    // Reset mid-operation: two loads hold credit, one is buffered, the other arrives during reset
    lat_lo = 1;
    lat_hi = 1;
    model_cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, iss);
    model_cycle(1'b0, 1'b1, 32'h104, 1'b1, 1'b0, iss);
    chk("rst_mid_buffered", u_bus.dataOut_valid, 1'b1);
    model_cycle(1'b1, 1'b0, 32'h108, 1'b1, 1'b0, iss);
    chk("rst_mid_dvalid", u_bus.dataOut_valid, 1'b0);
    obs_n = 0;
    // Full credit: three issues in a row must all be accepted
    for (int k = 0; k < 3; k++) begin
      model_cycle(1'b0, 1'b1, 32'h200 + 32'(k), 1'b1, 1'b0, iss);
      chk("rst_mid_credit", iss, 1'b1);
    end
    for (int k = 0; k < 10 && obs_n == 0; k++) model_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, iss);
    chk("rst_mid_new_load", obs_data, 32'h200 * 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
